// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one registered W-bit adder
// among N_REQ requesters. The winning operand pair is summed and captured in a
// single-entry response slot, tagged with the requester index.
//
// Handshakes (all channels): a transfer happens on a rising edge where both
// valid and ready are high. A producer may drop valid without a transfer.
// Ready on the request side never asserts on a requester whose valid is low.
// The response slot keeps rsp_sum/rsp_id stable while rsp_valid=1 and
// rsp_ready=0.
//
// Optional feature: define ADDER_RR_STATS_EN to add grant_cnt, which holds one
// 8-bit saturating grant counter per requester.
module adder_rr_sched #(
  parameter  int N_REQ = 4,
  parameter  int W     = 2,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [W:0]         rsp_sum,
  output logic [IDW-1:0]     rsp_id,
`ifdef ADDER_RR_STATS_EN
  output logic [N_REQ*8-1:0] grant_cnt,
`endif
  input  logic               rsp_ready
);

  // Slot state: EMPTY/FULL. The state register is rsp_valid_q itself, so the
  // FSM state is visible on the rsp_valid output.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]     rsp_valid_q, rsp_valid_d;
  logic [W:0]     rsp_sum_q,   rsp_sum_d;
  logic [IDW-1:0] rsp_id_q,    rsp_id_d;
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;

  logic           grant_ok;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_idx;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic           grant;

  // Arbitration: scan upward from rr_ptr (wrapping) for the first valid
  // requester. A grant is allowed when the slot is empty or drains this cycle.
  always_comb begin
    grant_ok  = !i_rst && ((rsp_valid_q == ST_EMPTY) || rsp_ready);
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = rr_ptr_q + IDW'(i);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
    grant     = grant_ok && win_found;
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
    win_a = req_a[win_id*W +: W];
    win_b = req_b[win_id*W +: W];
  end

  // Next-state: load the slot on a grant, empty it when drained with no grant,
  // otherwise hold. The pointer moves past the winner only on a grant.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      rsp_valid_d = ST_FULL;
      rsp_sum_d   = {1'b0, win_a} + {1'b0, win_b};
      rsp_id_d    = win_id;
      rr_ptr_d    = win_id + IDW'(1);
    end else if ((rsp_valid_q == ST_FULL) && rsp_ready) begin
      rsp_valid_d = ST_EMPTY;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q <= ST_EMPTY;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q[0];
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_RR_STATS_EN
  logic [N_REQ-1:0][7:0] cnt_q;

  // Per-requester grant counters, saturating at 255.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_valid[k] && req_ready[k] && (cnt_q[k] != 8'hFF)) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
